// File: rtl/uart_tx_queue_pkg.sv
// -----------------------------------------------------------------------------
// utils : shared constants and types for the UART blocks.
//   CLK_PER_HALF_BIT    - transmitter bit-timing constant (existing).
//   UART_TXQ_DEPTH_LOG2 - default log2 depth of the UART TX byte queue.
//   txq_state_t         - dispatcher FSM states of uart_tx_queue.
// -----------------------------------------------------------------------------
package utils;

  localparam int CLK_PER_HALF_BIT    = 54;
  localparam int UART_TXQ_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// -----------------------------------------------------------------------------
// uart_tx_queue_if : bundle between uart_tx_queue and its surroundings.
//   wr_data/wr_valid/wr_ready - byte write handshake from the core / arbiter.
//   sdata/tx_start/tx_busy    - link to the UART transmitter.
//   count/drained             - queue status.
// Modports:
//   master - the environment (byte source plus transmitter).
//   slave  - the queue itself.
// DEPTH_LOG2 must match the DEPTH_LOG2 of the attached uart_tx_queue.
// -----------------------------------------------------------------------------
interface uart_tx_queue_if #(
  parameter int DEPTH_LOG2 = utils::UART_TXQ_DEPTH_LOG2
);

  logic [7:0]          wr_data;
  logic                wr_valid;
  logic                wr_ready;
  logic [7:0]          sdata;
  logic                tx_start;
  logic                tx_busy;
  logic [DEPTH_LOG2:0] count;
  logic                drained;

  modport master (
    output wr_data, wr_valid, tx_busy,
    input  wr_ready, sdata, tx_start, count, drained
  );

  modport slave (
    input  wr_data, wr_valid, tx_busy,
    output wr_ready, sdata, tx_start, count, drained
  );

endinterface

// File: rtl/uart_tx_queue_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo : single-clock circular-buffer FIFO, first-word-fall-through.
//   clk, rstn - clock, synchronous active-low reset.
//   push      - store push_data (ignored when full).
//   push_data - data to store.
//   pop       - drop the head entry (ignored when empty).
//   head      - oldest stored entry, valid whenever count != 0.
//   count     - number of stored entries, 0..2**DEPTH_LOG2.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = push && (r_count != FULL);
  assign w_do_pop  = pop  && (r_count != '0);

  // NOTE: storage is deliberately not reset; only the pointers and count
  // define which entries are meaningful, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap modulo depth.
  // NOTE: every register written on a clock edge uses <=, so all processes
  // see the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue : byte queue and dispatcher in front of the UART transmitter.
//   clk  - clock.
//   rstn - synchronous active-low reset (shared with the transmitter).
//   bus  - uart_tx_queue_if.slave:
//     wr_data/wr_valid/wr_ready : byte push handshake.
//     sdata    : byte presented to the transmitter, loaded on every pop.
//     tx_start : one-cycle start pulse, never issued while tx_busy is high.
//     tx_busy  : transmitter busy (registered, rises the cycle after tx_start).
//     count    : bytes stored in the FIFO (byte in flight excluded).
//     drained  : FIFO empty, dispatcher idle and transmitter not busy.
// The transmitter restarts on any tx_start, even mid-frame, so the dispatcher
// only pops when tx_busy is low and only pulses tx_start from ISSUE.
// -----------------------------------------------------------------------------
module uart_tx_queue
  import utils::*;
#(
  parameter int DEPTH_LOG2 = UART_TXQ_DEPTH_LOG2
) (
  input  logic             clk,
  input  logic             rstn,
  uart_tx_queue_if.slave   bus
);

  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  txq_state_t          r_state;
  txq_state_t          w_state_next;
  logic [7:0]          r_sdata;
  logic [7:0]          w_head;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_push;
  logic                w_pop;
  logic                w_tx_start;

  // Ready comes from the registered count, so a pop opens a slot only from
  // the following cycle.
  assign bus.wr_ready = (w_count != FULL);
  assign w_push       = bus.wr_valid && bus.wr_ready;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (w_push),
    .push_data (bus.wr_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_start   = 1'b0;
    case (r_state)
      IDLE: begin
        if ((w_count != '0) && !bus.tx_busy) begin
          w_pop        = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_tx_start   = 1'b1;
        w_state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // tx_busy is already high on entry, since ISSUE preceded this state.
        if (!bus.tx_busy) begin
          if (w_count != '0) begin
            w_pop        = 1'b1;
            w_state_next = ISSUE;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Loaded only on a pop, so sdata is stable throughout ISSUE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sdata <= 8'h00;
    end else if (w_pop) begin
      r_sdata <= w_head;
    end
  end

  assign bus.sdata    = r_sdata;
  assign bus.tx_start = w_tx_start;
  assign bus.count    = w_count;
  assign bus.drained  = (w_count == '0) && (r_state == IDLE) && !bus.tx_busy;

endmodule

// File: tb/tb_uart_tx_queue.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_queue : self-checking bench for uart_tx_queue (DEPTH_LOG2 = 2).
// A transmitter stand-in holds tx_busy high for FRAME cycles after each start
// and can be stalled. A queue-level model predicts every output each cycle;
// directed literal checks pin latency, ordering, backpressure and reset.
// -----------------------------------------------------------------------------
module tb_uart_tx_queue;
  import utils::*;

  localparam int DL    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_queue_if #(.DEPTH_LOG2(DL)) bus ();

  uart_tx_queue #(.DEPTH_LOG2(DL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Transmitter stand-in.
  bit r_busy   = 1'b0;
  bit stall    = 1'b0;
  int busy_cnt = 0;
  assign bus.tx_busy = r_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) begin
      r_busy   <= 1'b0;
      busy_cnt <= 0;
    end else if (bus.tx_start) begin
      r_busy   <= 1'b1;
      busy_cnt <= FRAME;
    end else if (r_busy && !stall) begin
      if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end else begin
        r_busy   <= 1'b0;
        busy_cnt <= 0;
      end
    end
  end

  // Observations.
  logic [7:0] tx_log[$];
  int         start_cyc[$];
  int         start_gap[$];
  int         last_fall = -100;
  bit         prev_busy = 1'b0;

  // Queue-level model: bytes waiting, byte last handed out, whether a start
  // is due this cycle, and whether a started frame has not yet been seen done.
  logic [7:0] m_q[$];
  logic [7:0] m_sdata     = 8'h00;
  bit         m_start_now = 1'b0;
  bit         m_waiting   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s @cycle %0d: bound expired", name, cyc);
  endtask

  // Model advance on each clock edge, from pre-edge inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_q.delete();
        m_sdata     = 8'h00;
        m_start_now = 1'b0;
        m_waiting   = 1'b0;
      end else begin
        bit push, pop;
        push = bus.wr_valid && (m_q.size() != DEPTH);
        pop  = (m_q.size() != 0) && !r_busy && !m_start_now;
        if (m_start_now)              m_waiting = 1'b1;
        else if (m_waiting && !r_busy) m_waiting = 1'b0;
        if (pop)  m_sdata = m_q.pop_front();
        if (push) m_q.push_back(bus.wr_data);
        m_start_now = pop;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("tx_start", bus.tx_start, m_start_now);
        check("sdata",    bus.sdata,    m_sdata);
        check("count",    bus.count,    m_q.size());
        check("wr_ready", bus.wr_ready, m_q.size() != DEPTH);
        check("drained",  bus.drained,
              (m_q.size() == 0) && !m_start_now && !m_waiting && !r_busy);
        if (bus.tx_start) begin
          check("start_while_busy", r_busy, 1'b0);
          tx_log.push_back(bus.sdata);
          start_cyc.push_back(cyc);
          start_gap.push_back(cyc - last_fall);
        end
        if (prev_busy && !r_busy) last_fall = cyc;
        prev_busy = r_busy;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic push_byte(input logic [7:0] b, output int acc);
    int budget;
    budget = 200;
    bus.wr_data  = b;
    bus.wr_valid = 1'b1;
    while (!bus.wr_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      timeout_fail("push_timeout");
      acc = -1;
    end else begin
      acc = cyc;
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_drained(output int when);
    int budget;
    budget = 500;
    while (!bus.drained && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) timeout_fail("drain_timeout");
    when = cyc;
  endtask

  task automatic wait_busy_low();
    int budget;
    budget = 200;
    while (r_busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) timeout_fail("busy_low_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d, base, nb, tmp;
    logic [7:0] exp_b;
    bus.wr_data  = 8'h00;
    bus.wr_valid = 1'b0;

    // Reset with tx_busy low.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_tx_start", bus.tx_start, 1'b0);
    check("rst_sdata",    bus.sdata,    8'h00);
    check("rst_count",    bus.count,    0);
    check("rst_wr_ready", bus.wr_ready, 1'b1);
    check("rst_drained",  bus.drained,  1'b1);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_start", start_cyc.size(), 0);

    // Single byte: start two cycles after the push, drained two cycles after
    // tx_busy has been high for the whole frame.
    base = tx_log.size();
    push_byte(8'hA5, t);
    wait_drained(d);
    check("single_frames",  tx_log.size() - base, 1);
    check("single_data",    tx_log[base], 8'hA5);
    check("single_latency", start_cyc[start_cyc.size()-1] - t, 2);
    check("single_drain",   d - start_cyc[start_cyc.size()-1], FRAME + 2);

    // Burst 01..05.
    base = tx_log.size();
    nb   = start_cyc.size();
    for (int i = 1; i <= 5; i++) push_byte(8'(i), tmp);
    wait_drained(d);
    check("burst_frames", tx_log.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      exp_b = 8'(i + 1);
      check("burst_order", tx_log[base+i], exp_b);
    end
    for (int i = 1; i < 5; i++) check("burst_gap", start_gap[nb+i], 1);

    // Full queue behind a stalled transmitter.
    stall = 1'b1;
    base  = tx_log.size();
    nb    = start_cyc.size();
    push_byte(8'h10, tmp);
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 4; i++) push_byte(8'(8'h10 + i), tmp);
    check("full_count",    bus.count,    4);
    check("full_wr_ready", bus.wr_ready, 1'b0);
    bus.wr_data  = 8'h15;
    bus.wr_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("full_hold_ready",  bus.wr_ready, 1'b0);
    check("full_hold_frames", tx_log.size() - base, 1);
    stall = 1'b0;
    push_byte(8'h15, t);
    check("full_accept_cycle", t, start_cyc[nb+1]);
    wait_drained(d);
    check("full_frames", tx_log.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      exp_b = 8'(8'h10 + i);
      check("full_order", tx_log[base+i], exp_b);
    end

    // Push and pop together with count == 1 at a frame boundary.
    stall = 1'b1;
    base  = tx_log.size();
    push_byte(8'h21, tmp);
    repeat (3) @(negedge clk);
    push_byte(8'h22, tmp);
    check("simul_pre_count", bus.count, 1);
    stall = 1'b0;
    wait_busy_low();
    push_byte(8'h23, tmp);
    check("simul_count",    bus.count,    1);
    check("simul_sdata",    bus.sdata,    8'h22);
    check("simul_tx_start", bus.tx_start, 1'b1);
    wait_drained(d);
    check("simul_frames", tx_log.size() - base, 3);
    check("simul_order0", tx_log[base],   8'h21);
    check("simul_order1", tx_log[base+1], 8'h22);
    check("simul_order2", tx_log[base+2], 8'h23);

    // Reset mid-frame with three bytes queued.
    stall = 1'b1;
    base  = tx_log.size();
    push_byte(8'h31, tmp);
    repeat (3) @(negedge clk);
    for (int i = 2; i <= 4; i++) push_byte(8'(8'h30 + i), tmp);
    check("mid_count", bus.count, 3);
    rstn  = 1'b0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("mid_rst_count",    bus.count,    0);
    check("mid_rst_drained",  bus.drained,  1'b1);
    check("mid_rst_wr_ready", bus.wr_ready, 1'b1);
    nb = start_cyc.size();
    repeat (30) @(negedge clk);
    check("mid_rst_no_start",  start_cyc.size() - nb, 0);
    check("mid_rst_frames",    tx_log.size() - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
